// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: engine state encoding, default counter width and a one-hot helper
package timer_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CNT_W_DEF = 27;
  function automatic logic [7:0] onehot(input logic [2:0] i);
    return 8'(1) << i;
  endfunction
endpackage

// File: rtl/timer_sched_if.sv
// timer_sched_if: requester bus (master: req/len/irq_en/irq_clr out; grant/busy/done/irq_status/irq in; slave: reverse)
interface timer_sched_if
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = CNT_W_DEF
);
  logic [NUM_REQ-1:0] req, grant, done, irq_en, irq_clr, irq_status;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic busy, irq;
  modport master (output req, len, irq_en, irq_clr, input grant, busy, done, irq_status, irq);
  modport slave (input req, len, irq_en, irq_clr, output grant, busy, done, irq_status, irq);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first req at or after ptr (req/ptr in; gnt one-hot, idx, valid out)
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = PW'((int'(ptr) + k) % N);
  end
  assign valid = |req;
  assign gnt = valid ? N'(onehot(3'(idx))) : '0;
endmodule

// File: rtl/timer_sched.sv
// timer_sched: round-robin shared timeout engine with done pulses and sticky maskable irq (clk, rst_n, bus slave)
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  timer_sched_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, win_len;
  logic [PW-1:0] owner, owner_nxt, ptr, ptr_nxt, win_idx, inc;
  logic [NUM_REQ-1:0] win_oh, gr, gr_nxt, done_v, st;
  logic win_v;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req(bus.req), .ptr(ptr), .gnt(win_oh), .idx(win_idx), .valid(win_v));
  assign win_len = bus.len[int'(win_idx) * CNT_W +: CNT_W];
  assign inc = owner == PW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
  assign bus.busy = state != IDLE;
  assign bus.grant = bus.busy ? gr : '0;
  assign done_v = state == DONE ? gr : '0;
  assign bus.done = done_v;
  assign bus.irq_status = st;
  assign bus.irq = |(st & bus.irq_en);
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    owner_nxt = owner;
    ptr_nxt = ptr;
    gr_nxt = gr;
    case (state)
      IDLE: if (win_v) begin
        nxt = RUN;
        owner_nxt = win_idx;
        gr_nxt = win_oh;
        cnt_nxt = win_len == '0 ? '0 : win_len - 1'b1;
      end
      RUN: if (!(|(bus.req & gr))) begin
        nxt = IDLE;
        ptr_nxt = inc;
      end else if (cnt == '0) nxt = DONE;
      else cnt_nxt = cnt - 1'b1;
      DONE: begin
        nxt = IDLE;
        ptr_nxt = inc;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      owner <= '0;
      ptr <= '0;
      gr <= '0;
      st <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      owner <= owner_nxt;
      ptr <= ptr_nxt;
      gr <= gr_nxt;
      st <= (st & ~bus.irq_clr) | done_v;
    end
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: table, directed corner sequences and randomized scoreboard for timer_sched
module tb_timer_sched;
  logic clk = 0;
  logic rst_n = 0;
  int n_chk = 0, n_fail = 0, cyc = 0;
  timer_sched_if #(.NUM_REQ(4), .CNT_W(27)) bus ();
  timer_sched #(.NUM_REQ(4), .CNT_W(27)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] req;
    int         len;
    logic [3:0] en;
    logic [3:0] exp_g;
    int         exp_l;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic set_len(input int i, input int v);
    bus.len[i*27 +: 27] = 27'(v);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done == 4'h0 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    bus.req = 0;
    bus.irq_clr = 0;
    bus.irq_en = 0;
    bus.len = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, prev;
    bit saw;
    logic [3:0] r, mst, men, clr, eg, ed;
    int own, g, l, mptr;
    bit eng;
    int lens[4];
    tbl[0] = '{4'b0001, 5, 4'b0001, 4'b0001, 5};
    tbl[1] = '{4'b0010, 0, 4'b0000, 4'b0010, 1};
    tbl[2] = '{4'b0010, 1, 4'b0010, 4'b0010, 1};
    tbl[3] = '{4'b1000, 3, 4'b0111, 4'b1000, 3};
    tbl[4] = '{4'b0100, 7, 4'b0100, 4'b0100, 7};
    tbl[5] = '{4'b0001, 5, 4'b0000, 4'b0001, 5};
    bus.req = 0;
    bus.irq_clr = 0;
    bus.irq_en = 0;
    bus.len = '0;
    @(negedge clk);
    chk("reset", {bus.grant, bus.busy, bus.done, bus.irq_status, bus.irq}, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.irq_clr = '1;
      bus.req = 0;
      @(negedge clk);
      bus.irq_clr = 0;
      for (int j = 0; j < 4; j++) set_len(j, tbl[i].len);
      bus.irq_en = tbl[i].en;
      bus.req = tbl[i].req;
      @(negedge clk);
      chk("tbl_grant", bus.grant, tbl[i].exp_g);
      chk("tbl_busy", bus.busy, 1);
      wait_done(n);
      chk("tbl_latency", n, tbl[i].exp_l);
      chk("tbl_done", bus.done, tbl[i].exp_g);
      chk("tbl_st_early", bus.irq_status, 0);
      bus.req = 0;
      @(negedge clk);
      chk("tbl_done_width", bus.done, 0);
      chk("tbl_status", bus.irq_status, tbl[i].exp_g);
      chk("tbl_irq", bus.irq, |(tbl[i].exp_g & tbl[i].en));
    end
    do_reset();
    for (int j = 0; j < 4; j++) set_len(j, 2);
    bus.req = 4'hf;
    prev = 0;
    for (int j = 0; j < 4; j++) begin
      wait_done(n);
      chk("rr_done", bus.done, 32'(1 << j));
      if (j > 0) chk("rr_gap", cyc - prev, 4);
      prev = cyc;
      bus.req[j] = 0;
      @(negedge clk);
    end
    bus.irq_clr = '1;
    @(negedge clk);
    bus.irq_clr = 0;
    set_len(2, 100);
    bus.req = 4'b0100;
    @(negedge clk);
    chk("abort_grant", bus.grant, 4'b0100);
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done != 0) saw = 1;
    end
    bus.req = 0;
    @(negedge clk);
    chk("abort_idle", {bus.grant, bus.busy}, 0);
    chk("abort_nodone", saw, 0);
    chk("abort_status", bus.irq_status, 0);
    set_len(0, 2);
    set_len(1, 2);
    bus.req = 4'b0011;
    @(negedge clk);
    chk("wrap_grant", bus.grant, 4'b0001);
    wait_done(n);
    chk("wrap_done", bus.done, 4'b0001);
    bus.req[0] = 0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_next", bus.grant, 4'b0010);
    wait_done(n);
    bus.req[1] = 0;
    @(negedge clk);
    chk("wrap_status", bus.irq_status, 4'b0011);
    set_len(2, 1);
    bus.req = 4'b0100;
    @(negedge clk);
    wait_done(n);
    chk("len1_latency", n, 1);
    bus.req = 0;
    @(negedge clk);
    chk("set_status", bus.irq_status, 4'b0111);
    set_len(2, 3);
    bus.req = 4'b0100;
    @(negedge clk);
    wait_done(n);
    bus.irq_clr = 4'b0100;
    bus.req = 0;
    @(negedge clk);
    bus.irq_clr = 0;
    chk("set_wins", bus.irq_status, 4'b0111);
    bus.irq_en = 4'b0100;
    #1;
    chk("irq_comb", bus.irq, 1);
    @(negedge clk);
    bus.irq_clr = 4'b0100;
    @(negedge clk);
    bus.irq_clr = 0;
    chk("clr_status", bus.irq_status, 4'b0011);
    chk("clr_irq", bus.irq, 0);
    set_len(0, 50);
    bus.req = 4'b0001;
    @(negedge clk);
    chk("rst_pre_grant", bus.grant, 4'b0001);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst", {bus.grant, bus.busy, bus.done, bus.irq_status, bus.irq}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_regrant", bus.grant, 4'b0001);
    wait_done(n);
    chk("rst_full_len", n, 50);
    bus.req = 0;
    do_reset();
    r = 0;
    mst = 0;
    men = 0;
    eng = 0;
    mptr = 0;
    own = 0;
    g = 0;
    l = 0;
    for (int i = 0; i < 4; i++) lens[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      eg = eng ? 4'(1 << own) : 4'h0;
      ed = (eng && k == g + l) ? eg : 4'h0;
      chk("rand", {bus.grant, bus.busy, bus.done, bus.irq_status, bus.irq}, {eg, eng, ed, mst, |(mst & men)});
      if (ed != 0) begin
        r[own] = 0;
        mptr = (own + 1) % 4;
        eng = 0;
      end
      for (int i = 0; i < 4; i++)
        if (!r[i] && $urandom_range(7) == 0) begin
          r[i] = 1;
          lens[i] = $urandom_range(6);
          set_len(i, lens[i]);
        end
      clr = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'h0;
      if (k % 64 == 0) men = 4'($urandom_range(15));
      bus.req = r;
      bus.irq_clr = clr;
      bus.irq_en = men;
      mst = (mst & ~clr) | ed;
      if (ed == 0 && !eng && r != 0) begin
        own = pick(r, mptr);
        g = k + 1;
        l = lens[own] == 0 ? 1 : lens[own];
        eng = 1;
      end
    end
    bus.req = 0;
    bus.irq_clr = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
